// File: rtl/bird_pkg.sv
// Shared constants for the bird display path: sprite mode codes, FSM states, screen geometry.
package bird_pkg;

  localparam logic [1:0] MODE_HOVER = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_DEAD  = 2'b11;

  // State encodings double as the sprite mode code so the output needs no decode.
  typedef enum logic [1:0] {
    IDLE = MODE_HOVER,
    FLY  = MODE_RISE,
    FALL = MODE_FALL,
    DEAD = MODE_DEAD
  } bird_state_t;

  localparam int unsigned SCREEN_H         = 480;
  localparam int unsigned GROUND_Y_DEFAULT = 448;

endpackage

// File: rtl/bird_motion_controller_flap.sv
// Flap button conditioning: 2-flop synchroniser, optional debounce (FLAP_DEBOUNCE_EN), rising-edge pulse.
module flap_input_conditioner #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, level, level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef FLAP_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          filt;

  // cnt counts consecutive cycles the synchronised input disagrees with the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync2 == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt  <= '0;
      filt <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/bird_motion_controller.sv
// Bird physics and mode FSM; produces bird_y and the sprite mode code. Debounce via FLAP_DEBOUNCE_EN.
module bird_motion_controller
  import bird_pkg::*;
#(
  parameter int          GRAVITY    = 1,
  parameter int          FLAP_VEL   = 8,
  parameter int          MAX_FALL   = 6,
  parameter int          START_Y    = 240,
  parameter int          GROUND_Y   = int'(GROUND_Y_DEFAULT),
  parameter int          VEL_W      = 8,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flap_btn,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       game_start,
  output logic [1:0] state_output,
  output logic [9:0] bird_y,
  output logic       alive
);

  localparam logic signed [VEL_W:0] GRAV_V   = (VEL_W + 1)'(GRAVITY);
  localparam logic signed [VEL_W:0] FLAP_V   = (VEL_W + 1)'(-FLAP_VEL);
  localparam logic signed [VEL_W:0] MAXF_V   = (VEL_W + 1)'(MAX_FALL);
  localparam logic signed [10:0]    GROUND_S = 11'(GROUND_Y);
  localparam logic [9:0]            GROUND_V = 10'(GROUND_Y);
  localparam logic [9:0]            START_V  = 10'(START_Y);

  bird_state_t             state_q, state_d, phys_state;
  logic [9:0]              y_q, y_d, phys_y;
  logic signed [VEL_W-1:0] vel_q, vel_d, phys_vel;
  logic signed [VEL_W:0]   vel_inc, vel_n;
  logic signed [10:0]      y_n;
  logic                    pending_q, pending_d, flap_edge, flap_now;

  flap_input_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_flap (
    .clk  (clk),
    .rst  (rst),
    .btn  (flap_btn),
    .pulse(flap_edge)
  );

  // An edge arriving with the consuming tick is folded into that tick's flap.
  always_comb begin
    flap_now = pending_q | flap_edge;
    vel_inc  = (VEL_W + 1)'(vel_q) + GRAV_V;
    if (flap_now)              vel_n = FLAP_V;
    else if (vel_inc > MAXF_V) vel_n = MAXF_V;
    else                       vel_n = vel_inc;
    y_n        = $signed({1'b0, y_q}) + 11'(vel_n);
    phys_y     = y_n[9:0];
    phys_vel   = vel_n[VEL_W-1:0];
    phys_state = (vel_n < 0) ? FLY : FALL;
    if (y_n < 0) begin
      phys_y     = '0;
      phys_vel   = '0;
      phys_state = FALL;
    end else if (y_n >= GROUND_S) begin
      phys_y     = GROUND_V;
      phys_state = DEAD;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    vel_d     = vel_q;
    pending_d = flap_now;
    if (game_start) begin
      state_d   = IDLE;
      y_d       = START_V;
      vel_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick && flap_now) begin
            state_d   = phys_state;
            y_d       = phys_y;
            vel_d     = phys_vel;
            pending_d = 1'b0;
          end
        end
        FLY, FALL: begin
          if (collision) begin
            state_d   = DEAD;
            pending_d = 1'b0;
          end else if (frame_tick) begin
            state_d   = phys_state;
            y_d       = phys_y;
            vel_d     = phys_vel;
            pending_d = 1'b0;
          end
        end
        DEAD:    pending_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= START_V;
      vel_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      pending_q <= pending_d;
    end
  end

  assign state_output = state_q;
  assign bird_y       = y_q;
  assign alive        = (state_q != DEAD);

endmodule

// File: tb/tb_bird_motion_controller.sv
// Directed plus randomized bench for bird_motion_controller against a cycle-level behavioural model.
module tb_bird_motion_controller;

`ifdef FLAP_DEBOUNCE_EN
  localparam int unsigned DEB    = 16;
  localparam int          HOLD   = 22;
  localparam int          SETTLE = 24;
  localparam int          FLIP   = 40;
`else
  localparam int unsigned DEB    = 250000;
  localparam int          HOLD   = 2;
  localparam int          SETTLE = 4;
  localparam int          FLIP   = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flap_btn = 1'b0, frame_tick = 1'b0, collision = 1'b0, game_start = 1'b0;
  logic [1:0] state_output;
  logic [9:0] bird_y;
  logic       alive;

  int checks = 0;
  int errors = 0;

  bird_motion_controller #(.DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .flap_btn    (flap_btn),
    .frame_tick  (frame_tick),
    .collision   (collision),
    .game_start  (game_start),
    .state_output(state_output),
    .bird_y      (bird_y),
    .alive       (alive)
  );

  always #5 clk = ~clk;

  // Model: mode 0 hover, 1 rising, 2 falling, 3 dead.
  int m_mode, m_y, m_vel;
  bit m_pend;
  bit lv0, lv1, prev_btn;
`ifdef FLAP_DEBOUNCE_EN
  bit sh[$];
`endif

  task automatic model_reset();
    m_mode = 0; m_y = 240; m_vel = 0; m_pend = 0;
    lv0 = 0; lv1 = 0; prev_btn = 0;
`ifdef FLAP_DEBOUNCE_EN
    sh.delete();
`endif
  endtask

  task automatic physics(input bit flap);
    int v, y;
    v = flap ? -8 : ((m_vel + 1 > 6) ? 6 : m_vel + 1);
    y = m_y + v;
    if (y < 0) begin
      m_y = 0; m_vel = 0; m_mode = 2;
    end else if (y >= 448) begin
      m_y = 448; m_vel = v; m_mode = 3;
    end else begin
      m_y = y; m_vel = v; m_mode = (v < 0) ? 1 : 2;
    end
  endtask

  task automatic model_edge(input bit b, input bit t, input bit c, input bit g);
    bit pulse, flap, new_lv;
    pulse = lv0 && !lv1;
    flap  = m_pend || pulse;
    if (g) begin
      m_mode = 0; m_y = 240; m_vel = 0; m_pend = 0;
    end else if (m_mode == 3) begin
      m_pend = 0;
    end else if (m_mode != 0 && c) begin
      m_mode = 3; m_pend = 0;
    end else if (t && (m_mode != 0 || flap)) begin
      physics(flap); m_pend = 0;
    end else begin
      m_pend = flap;
    end
`ifdef FLAP_DEBOUNCE_EN
    begin
      bit same;
      same = (sh.size() >= int'(DEB));
      if (same) for (int i = 0; i < int'(DEB); i++) if (sh[i] == lv0) same = 0;
      new_lv = same ? !lv0 : lv0;
      sh.push_front(prev_btn);
      if (sh.size() > int'(DEB)) void'(sh.pop_back());
    end
`else
    new_lv = prev_btn;
`endif
    lv1 = lv0;
    lv0 = new_lv;
    prev_btn = b;
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (state_output === 2'(m_mode)) else begin
      errors++; $error("FAIL %s state_output got %0d exp %0d", tag, state_output, m_mode);
    end
    checks++;
    assert (bird_y === 10'(m_y)) else begin
      errors++; $error("FAIL %s bird_y got %0d exp %0d", tag, bird_y, m_y);
    end
    checks++;
    assert (alive === (m_mode != 3)) else begin
      errors++; $error("FAIL %s alive got %0b exp %0b", tag, alive, m_mode != 3);
    end
  endtask

  task automatic check_const(input string tag, input int mode, input int y);
    checks++;
    assert (state_output === 2'(mode)) else begin
      errors++; $error("FAIL %s state_output got %0d exp %0d", tag, state_output, mode);
    end
    checks++;
    assert (bird_y === 10'(y)) else begin
      errors++; $error("FAIL %s bird_y got %0d exp %0d", tag, bird_y, y);
    end
    checks++;
    assert (alive === (mode != 3)) else begin
      errors++; $error("FAIL %s alive got %0b exp %0b", tag, alive, mode != 3);
    end
  endtask

  task automatic step(input bit b, input bit t, input bit c, input bit g, input string tag);
    flap_btn = b; frame_tick = t; collision = c; game_start = g;
    @(posedge clk);
    model_edge(b, t, c, g);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic press();
    for (int i = 0; i < HOLD; i++)   step(1, 0, 0, 0, "press");
    for (int i = 0; i < SETTLE; i++) step(0, 0, 0, 0, "release");
  endtask

  task automatic tick(input string tag);
    step(0, 1, 0, 0, tag);
  endtask

  initial begin
    bit rb;
    int guard;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_const("reset", 0, 240);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) tick("idle_tick");
    check_const("idle_hold", 0, 240);

    press();
    tick("t0");  check_const("tick0", 1, 232);
    tick("t1");  check_const("tick1", 1, 225);
    for (int i = 2; i <= 8; i++) tick("tn");
    check_const("tick8", 2, 204);

    guard = 0;
    while (m_mode != 3 && guard < 100) begin tick("fall"); guard++; end
    check_const("ground", 3, 448);
    press(); tick("dead_t"); tick("dead_t");
    check_const("ground_hold", 3, 448);
    step(0, 0, 0, 1, "gs");
    check_const("restart", 0, 240);

    press(); tick("ceil_first");
    guard = 0;
    while (!(m_mode == 2 && m_y == 0) && guard < 60) begin press(); tick("ceil"); guard++; end
    check_const("ceiling", 2, 0);
    press(); tick("ceil_again");
    check_const("ceiling_again", 2, 0);

    step(0, 0, 0, 1, "gs2");
    press(); tick("fly");
    step(0, 0, 1, 0, "coll");
    check_const("collision", 3, 232);
    press(); tick("cd"); tick("cd");
    check_const("coll_frozen", 3, 232);
    step(0, 0, 0, 1, "gs3");
    check_const("coll_restart", 0, 240);

    press(); tick("h0");
    for (int i = 1; i <= 8; i++) tick("h");
    check_const("pre_gs_coll", 2, 204);
    step(1, 1, 1, 1, "gs_coll");
    check_const("gs_over_coll", 0, 240);

    press(); tick("r0");
    for (int i = 1; i <= 9; i++) tick("r");
    rst = 1'b1;
    #2;
    model_reset();
    check_const("async_rst", 0, 240);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick("post_rst");
    check_const("post_rst_idle", 0, 240);

`ifdef FLAP_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, "glitch");
    for (int i = 0; i < 24; i++) step(0, 0, 0, 0, "glitch_rel");
    tick("glitch_t");
    check_const("glitch_ignored", 0, 240);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, "long");
    for (int i = 0; i < 24; i++) step(0, 0, 0, 0, "long_rel");
    tick("long_t");
    check_const("long_accepted", 1, 232);
`endif

    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, FLIP) == 0) rb = !rb;
      step(rb, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
